// File: rtl/upg_loader.sv
// rtl/upg_loader.sv - UART framed program loader driving the memory programming port
module upg_loader #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_WORDS      = 16384
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        upg_wen_o,
    output logic        upg_sel_o,
    output logic [13:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        err_o
);

    localparam int              TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]     MAX_N    = 16'(MAX_WORDS);
    localparam logic [7:0]      HDR      = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TARGET,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t         state;
    logic           tgt_sel;
    logic [7:0]     len_lo;
    logic [15:0]    len;
    logic [15:0]    word_idx;
    logic [1:0]     byte_idx;
    logic [23:0]    word_buf;
    logic [7:0]     csum;
    logic [TW-1:0]  tmo_cnt;

    logic [15:0]    len_n;
    logic [15:0]    idx_inc;
    logic [7:0]     csum_n;
    logic           in_frame;

    // Next-value helpers shared by the parser below
    always_comb begin
        len_n    = {rx_data, len_lo};
        idx_inc  = word_idx + 16'd1;
        csum_n   = csum ^ rx_data;
        in_frame = (state == S_TARGET) || (state == S_LEN_LO) || (state == S_LEN_HI)
                || (state == S_DATA)   || (state == S_CSUM);
    end

    // Frame parser, word assembly, write strobe and inter-byte timeout
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tgt_sel    <= 1'b0;
            len_lo     <= 8'd0;
            len        <= 16'd0;
            word_idx   <= 16'd0;
            byte_idx   <= 2'd0;
            word_buf   <= 24'd0;
            csum       <= 8'd0;
            tmo_cnt    <= '0;
            upg_wen_o  <= 1'b0;
            upg_sel_o  <= 1'b0;
            upg_adr_o  <= 14'd0;
            upg_dat_o  <= 32'd0;
            upg_done_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            upg_wen_o <= 1'b0;
            if (rx_valid) begin
                // A byte always wins over a simultaneous timeout terminal count
                tmo_cnt <= '0;
                case (state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (rx_data == HDR) begin
                            state      <= S_TARGET;
                            upg_done_o <= 1'b0;
                            err_o      <= 1'b0;
                        end
                    end
                    S_TARGET: begin
                        if (rx_data[7:1] == 7'd0) begin
                            tgt_sel <= rx_data[0];
                            state   <= S_LEN_LO;
                        end else begin
                            state <= S_ERROR;
                            err_o <= 1'b1;
                        end
                    end
                    S_LEN_LO: begin
                        len_lo <= rx_data;
                        state  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        if ((len_n == 16'd0) || (len_n > MAX_N)) begin
                            state <= S_ERROR;
                            err_o <= 1'b1;
                        end else begin
                            len      <= len_n;
                            word_idx <= 16'd0;
                            byte_idx <= 2'd0;
                            csum     <= 8'd0;
                            state    <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        csum     <= csum_n;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    word_buf[7:0]   <= rx_data;
                            2'd1:    word_buf[15:8]  <= rx_data;
                            2'd2:    word_buf[23:16] <= rx_data;
                            default: begin
                                // Address, data and target only move on a strobe
                                upg_wen_o <= 1'b1;
                                upg_sel_o <= tgt_sel;
                                upg_adr_o <= word_idx[13:0];
                                upg_dat_o <= {rx_data, word_buf};
                                word_idx  <= idx_inc;
                                if (idx_inc == len) begin
                                    state <= S_CSUM;
                                end
                            end
                        endcase
                    end
                    S_CSUM: begin
                        if (rx_data == csum) begin
                            state      <= S_DONE;
                            upg_done_o <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            err_o <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (in_frame) begin
                if (tmo_cnt == TMO_LAST) begin
                    state      <= S_ERROR;
                    err_o      <= 1'b1;
                    upg_done_o <= 1'b0;
                    tmo_cnt    <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_upg_loader.sv
// tb/tb_upg_loader.sv - directed self-checking bench for upg_loader
module tb_upg_loader;

    logic        clock;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        upg_wen_o;
    logic        upg_sel_o;
    logic [13:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        err_o;

    int          n_checks;
    int          n_errors;
    int          wr_total;
    int          base;
    logic        log_sel [0:63];
    logic [13:0] log_adr [0:63];
    logic [31:0] log_dat [0:63];
    logic [7:0]  fr [$];

    upg_loader #(.TIMEOUT_CYCLES(16), .MAX_WORDS(16384)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .upg_wen_o  (upg_wen_o),
        .upg_sel_o  (upg_sel_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .err_o      (err_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Log every write strobe seen just after a rising edge
    always @(posedge clock) begin
        #1;
        if (upg_wen_o) begin
            if (wr_total < 64) begin
                log_sel[wr_total] = upg_sel_o;
                log_adr[wr_total] = upg_adr_o;
                log_dat[wr_total] = upg_dat_o;
            end
            wr_total = wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte was sampled
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic send_fr(input int gap);
        foreach (fr[i]) begin
            send_byte(fr[i]);
            repeat (gap) @(negedge clock);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic sel,
                            input logic [13:0] adr, input logic [31:0] dat);
        if (idx < 64) begin
            check({tag, "_sel"}, 32'(log_sel[idx]), 32'(sel));
            check({tag, "_adr"}, 32'(log_adr[idx]), 32'(adr));
            check({tag, "_dat"}, log_dat[idx], dat);
        end else begin
            check({tag, "_idx"}, 32'(idx), 32'd63);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        wr_total = 0;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset values
        repeat (2) @(negedge clock);
        check("rst_wen",  32'(upg_wen_o),  32'd0);
        check("rst_sel",  32'(upg_sel_o),  32'd0);
        check("rst_adr",  32'(upg_adr_o),  32'd0);
        check("rst_dat",  upg_dat_o,       32'd0);
        check("rst_done", 32'(upg_done_o), 32'd0);
        check("rst_err",  32'(err_o),      32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);

        // Data-memory download with gaps between bytes
        base = wr_total;
        fr = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88};
        send_fr(2);
        send_byte(8'h88);
        check("dl_done", 32'(upg_done_o), 32'd1);
        check("dl_err",  32'(err_o),      32'd0);
        check("dl_nwr",  32'(wr_total - base), 32'd2);
        check_wr("dl_w0", base,     1'b1, 14'd0, 32'h44332211);
        check_wr("dl_w1", base + 1, 1'b1, 14'd1, 32'h88776655);
        repeat (3) @(negedge clock);

        // Bad checksum: writes still happen, frame flagged
        base = wr_total;
        send_byte(8'hA5);
        check("bc_done_drop", 32'(upg_done_o), 32'd0);
        fr = '{8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        send_fr(1);
        check("bc_err",  32'(err_o),      32'd1);
        check("bc_done", 32'(upg_done_o), 32'd0);
        check("bc_nwr",  32'(wr_total - base), 32'd2);

        // Invalid target byte
        base = wr_total;
        send_byte(8'hA5);
        check("tg_err_clr", 32'(err_o), 32'd0);
        send_byte(8'h02);
        check("tg_err", 32'(err_o), 32'd1);
        // Zero length
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_fr(0);
        check("l0_err", 32'(err_o), 32'd1);
        // Length 16385
        fr = '{8'hA5, 8'h00, 8'h01, 8'h40};
        send_fr(0);
        check("lmax_err", 32'(err_o), 32'd1);
        // Bytes following a rejected header are not data
        fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_fr(0);
        repeat (2) @(negedge clock);
        check("hdr_nwr",  32'(wr_total - base), 32'd0);
        check("hdr_done", 32'(upg_done_o), 32'd0);

        // Timeout after the 2nd data byte
        base = wr_total;
        fr = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
        send_fr(0);
        repeat (15) @(negedge clock);
        check("to_err_15", 32'(err_o), 32'd0);
        @(negedge clock);
        check("to_err_16", 32'(err_o), 32'd1);
        repeat (4) @(negedge clock);
        fr = '{8'h33, 8'h44, 8'h00};
        send_fr(1);
        check("to_late_nwr",  32'(wr_total - base), 32'd0);
        check("to_late_err",  32'(err_o),      32'd1);
        check("to_late_done", 32'(upg_done_o), 32'd0);

        // Back-to-back data-memory frame
        base = wr_total;
        fr = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_fr(0);
        check("b2b_done", 32'(upg_done_o), 32'd1);
        check("b2b_err",  32'(err_o),      32'd0);
        check("b2b_nwr",  32'(wr_total - base), 32'd1);
        check_wr("b2b_w0", base, 1'b1, 14'd0, 32'hEFBEADDE);

        // Reload into instruction memory
        base = wr_total;
        send_byte(8'hA5);
        check("rl_done_drop", 32'(upg_done_o), 32'd0);
        fr = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
        send_fr(0);
        check("rl_done", 32'(upg_done_o), 32'd1);
        check("rl_nwr",  32'(wr_total - base), 32'd2);
        check_wr("rl_w0", base,     1'b0, 14'd0, 32'h04030201);
        check_wr("rl_w1", base + 1, 1'b0, 14'd1, 32'h08070605);
        repeat (2) @(negedge clock);

        // Reset after the 3rd data byte
        base = wr_total;
        fr = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        send_fr(0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_wen",  32'(upg_wen_o),  32'd0);
        check("mr_sel",  32'(upg_sel_o),  32'd0);
        check("mr_adr",  32'(upg_adr_o),  32'd0);
        check("mr_dat",  upg_dat_o,       32'd0);
        check("mr_done", 32'(upg_done_o), 32'd0);
        check("mr_err",  32'(err_o),      32'd0);
        @(negedge clock);
        send_byte(8'hDD);
        rst_n = 1'b1;
        @(negedge clock);
        check("mr_nwr", 32'(wr_total - base), 32'd0);
        fr = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_fr(0);
        check("mr_ld_done", 32'(upg_done_o), 32'd1);
        check("mr_ld_nwr",  32'(wr_total - base), 32'd1);
        check_wr("mr_ld_w0", base, 1'b0, 14'd0, 32'h04030201);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
